cache_line_fill: RTL and testbench

- Line-fill engine between the L1 cache miss logic and the system memory bus.
- Accepts one miss request (address plus requester id) from the cache and issues a single line-aligned read on the bus request channel.
- Collects the response beats into a full 64-byte line and returns the assembled line to the cache with a one-cycle done pulse.
- One fill in flight at a time; the cache owns replacement and insertion.

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_line_fill.sv | 122 ++++++++++++
 tb/tb_cache_line_fill.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Types and constants shared between the L1 cache and its line-fill engine.
package cache_pkg;

  localparam int LINE_BYTES    = 64;
  localparam int OFFSET_SIZE_B = $clog2(LINE_BYTES);
  localparam int BEATS         = LINE_BYTES * 8 / 64;

  typedef enum logic [1:0] {
    IREAD = 2'd0,
    READ1 = 2'd1,
    READ2 = 2'd2
  } fill_src_t;

  typedef logic [LINE_BYTES*8-1:0] cache_line_data_t;

  localparam logic [12:0] MEM_READ = 13'h1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } fill_state_t;

endpackage

// File: rtl/cache_line_fill.sv
// Line-fill engine: one line-aligned bus read per miss, beats assembled into a
// full cache line and handed back to the cache with a one-cycle done pulse.
module cache_line_fill
  import cache_pkg::*;
#(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       LINE_BYTES     = cache_pkg::LINE_BYTES,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = cache_pkg::MEM_READ
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fill_req,
  input  logic [63:0]               fill_addr,
  input  logic [1:0]                fill_src,
  output logic                      fill_ready,
  output logic                      fill_done,
  output logic [LINE_BYTES*8-1:0]   fill_line,
  output logic [63:0]               fill_line_addr,
  output logic [1:0]                fill_done_src,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int BEATS_L = LINE_BYTES * 8 / BUS_DATA_WIDTH;
  localparam int IDX_W   = $clog2(BEATS_L);
  localparam int CNT_W   = IDX_W + 1;
  localparam int OFF_W   = $clog2(LINE_BYTES);

  fill_state_t               state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [63:0]               addr_q, addr_d;
  logic [1:0]                src_q, src_d;
  logic [LINE_BYTES*8-1:0]   line_q, line_d;
  logic                      respack_q, respack_d;

  // The response tag is deliberately ignored; only one read is ever outstanding.
  logic unused_resptag_s;
  assign unused_resptag_s = ^bus_resptag;

  // State, counter and line registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      src_q     <= 2'd0;
      line_q    <= '0;
      respack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      line_q    <= line_d;
      respack_q <= respack_d;
    end
  end

  // Next-state logic: accept, wait for request ack, collect beats, signal done.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    src_d     = src_q;
    line_d    = line_q;
    respack_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_req) begin
          addr_d  = {fill_addr[63:OFF_W], {OFF_W{1'b0}}};
          src_d   = fill_src;
          count_d = '0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      // A beat arriving alongside the ack is dropped: memory never answers first.
      S_REQ: begin
        if (bus_reqack) begin
          state_d = S_RESP;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        if (bus_respcyc) begin
          line_d[int'(count_q[IDX_W-1:0]) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
          count_d   = count_q + CNT_W'(1);
          respack_d = 1'b1;
          if (count_q == CNT_W'(BEATS_L - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign fill_ready     = (state_q == S_IDLE);
  assign fill_done      = (state_q == S_DONE);
  assign fill_line      = line_q;
  assign fill_line_addr = addr_q;
  assign fill_done_src  = src_q;
  assign bus_reqcyc     = (state_q == S_REQ);
  assign bus_req        = (state_q == S_REQ) ? BUS_DATA_WIDTH'(addr_q) : '0;
  assign bus_reqtag     = (state_q == S_REQ) ? READ_TAG : '0;
  assign bus_respack    = respack_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Self-checking bench for cache_line_fill: directed and randomized fills
// compared against a beat-array reference of the expected line.
module tb_cache_line_fill;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_req;
  logic [63:0]  fill_addr;
  logic [1:0]   fill_src;
  logic         fill_ready;
  logic         fill_done;
  logic [511:0] fill_line;
  logic [63:0]  fill_line_addr;
  logic [1:0]   fill_done_src;
  logic         bus_reqcyc;
  logic         bus_reqack;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_respcyc;
  logic         bus_respack;
  logic [63:0]  bus_resp;
  logic [12:0]  bus_resptag;

  int checks = 0;
  int errors = 0;
  logic [63:0]  beat_data [8];
  logic [511:0] last_line;

  cache_line_fill dut (
    .clk(clk), .reset(reset),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_src(fill_src),
    .fill_ready(fill_ready), .fill_done(fill_done), .fill_line(fill_line),
    .fill_line_addr(fill_line_addr), .fill_done_src(fill_done_src),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference line: beat k occupies bits [k*64 +: 64].
  function automatic logic [511:0] model_line();
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat_data[k];
    return l;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},   fill_ready, 1'b1);
    chk({tag, "_done"},    fill_done, 1'b0);
    chk({tag, "_line"},    fill_line, 512'd0);
    chk({tag, "_laddr"},   fill_line_addr, 64'd0);
    chk({tag, "_src"},     fill_done_src, 2'd0);
    chk({tag, "_reqcyc"},  bus_reqcyc, 1'b0);
    chk({tag, "_req"},     bus_req, 64'd0);
    chk({tag, "_reqtag"},  bus_reqtag, 13'd0);
    chk({tag, "_respack"}, bus_respack, 1'b0);
  endtask

  task automatic run_fill(input logic [63:0] a, input logic [1:0] s, input int ack_dly,
                          input bit gaps, input int abort_at, input bit busy,
                          input logic [63:0] a2);
    logic [63:0] ea;
    int          done_seen;
    ea = a & ~64'h3F;
    done_seen = 0;
    chk("pre_ready", fill_ready, 1'b1);
    fill_req = 1'b1; fill_addr = a; fill_src = s;
    step();
    if (busy) begin
      fill_addr = a2;
    end else begin
      fill_req  = 1'b0;
      fill_addr = {$urandom(), $urandom()};
      fill_src  = 2'($urandom_range(0, 2));
    end
    for (int i = 0; i <= ack_dly; i++) begin
      chk("reqcyc",     bus_reqcyc, 1'b1);
      chk("bus_req",    bus_req, ea);
      chk("reqtag",     bus_reqtag, 13'h1100);
      chk("busy_ready", fill_ready, 1'b0);
      chk("early_ack",  bus_respack, 1'b0);
      if (i == ack_dly) begin
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      step();
    end
    bus_reqack = 1'b0; bus_respcyc = 1'b0;
    chk("reqcyc_drop", bus_reqcyc, 1'b0);
    chk("req_drop",    bus_req, 64'd0);
    chk("tag_drop",    bus_reqtag, 13'd0);
    chk("ack_beat",    bus_respack, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        bus_respcyc = 1'b0; bus_resp = {$urandom(), $urandom()};
        step();
        chk("gap_respack", bus_respack, 1'b0);
        chk("gap_done",    fill_done, 1'b0);
      end
      if (k == abort_at) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_reset_state("abort");
        return;
      end
      bus_respcyc = 1'b1; bus_resp = beat_data[k];
      step();
      bus_respcyc = 1'b0;
      chk("respack", bus_respack, 1'b1);
      if (fill_done) done_seen++;
    end
    chk("done_count", done_seen, 1);
    chk("done",       fill_done, 1'b1);
    chk("line",       fill_line, model_line());
    chk("line_addr",  fill_line_addr, ea);
    chk("done_src",   fill_done_src, s);
    chk("done_ready", fill_ready, 1'b0);
    last_line = model_line();
    step();
    chk("post_done",  fill_done, 1'b0);
    chk("post_ready", fill_ready, 1'b1);
    chk("post_line",  fill_line, last_line);
    chk("post_laddr", fill_line_addr, ea);
    chk("post_ack",   bus_respack, 1'b0);
  endtask

  initial begin
    reset = 1'b0; fill_req = 1'b0; fill_addr = 64'd0; fill_src = 2'd0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = 64'd0; bus_resptag = 13'd0;
    repeat (2) step();
    chk_reset_state("reset");
    reset = 1'b1;
    step();
    chk_reset_state("idle");

    // Basic fill with immediate ack and back-to-back beats.
    for (int k = 0; k < 8; k++) beat_data[k] = 64'hA000 + 64'(k);
    run_fill(64'h1000_0047, 2'd1, 0, 1'b0, -1, 1'b0, 64'd0);

    // Delayed ack: request held six cycles.
    for (int k = 0; k < 8; k++) beat_data[k] = {$urandom(), $urandom()};
    run_fill(64'h0000_0000_2345_67FF, 2'd2, 5, 1'b0, -1, 1'b0, 64'd0);

    // Gapped response with the basic payload.
    for (int k = 0; k < 8; k++) beat_data[k] = 64'hA000 + 64'(k);
    run_fill(64'h1000_0047, 2'd1, 1, 1'b1, -1, 1'b0, 64'd0);

    // Busy: a second request held high is only taken after DONE.
    for (int k = 0; k < 8; k++) beat_data[k] = {$urandom(), $urandom()};
    run_fill(64'h0000_0000_0000_5000, 2'd0, 2, 1'b0, -1, 1'b1, 64'h2000);
    for (int k = 0; k < 8; k++) beat_data[k] = {$urandom(), $urandom()};
    run_fill(64'h2000, 2'd2, 0, 1'b0, -1, 1'b0, 64'd0);

    // Reset after three beats, then a clean fill.
    run_fill(64'h4000_0010, 2'd1, 0, 1'b0, 3, 1'b0, 64'd0);
    for (int k = 0; k < 8; k++) beat_data[k] = 64'hB0 + 64'(k);
    run_fill(64'h3000, 2'd0, 0, 1'b0, -1, 1'b0, 64'd0);

    // Stray beats while idle.
    for (int i = 0; i < 4; i++) begin
      bus_respcyc = 1'b1; bus_resp = {$urandom(), $urandom()};
      step();
      chk("stray_ack",    bus_respack, 1'b0);
      chk("stray_ready",  fill_ready, 1'b1);
      chk("stray_reqcyc", bus_reqcyc, 1'b0);
      chk("stray_line",   fill_line, last_line);
    end
    bus_respcyc = 1'b0;

    // Randomized fills against the reference line.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 8; k++) beat_data[k] = {$urandom(), $urandom()};
      run_fill({$urandom(), $urandom()}, 2'($urandom_range(0, 2)),
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, 1'b0, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
